// File: rtl/move_collector_if.sv
// move_collector_if: groups the collector's FIFO-side and move-stream signals.
//   master : the collector (issues FIFO reads, sources the move stream)
//   slave  : the environment (square-unit FIFOs and the move evaluator)
// Signals:
//   start       pulse that begins or restarts a collection pass
//   unit_done   per-unit generator done flags
//   fifo_empty  per-unit FIFO empty flags
//   fifo_data   all FIFO read words, unit u at [u*SLOTS*MW +: SLOTS*MW]
//   fifo_rden   one-hot FIFO read enable
//   move_data / move_valid / move_ready  move stream handshake
//   busy, gen_done, move_count           pass status
interface move_collector_if #(
    parameter int NUM_UNITS = 64,
    parameter int SLOTS     = 8,
    parameter int MW        = 19
);
    logic                          start;
    logic [NUM_UNITS-1:0]          unit_done;
    logic [NUM_UNITS-1:0]          fifo_empty;
    logic [NUM_UNITS*SLOTS*MW-1:0] fifo_data;
    logic [NUM_UNITS-1:0]          fifo_rden;
    logic [MW-1:0]                 move_data;
    logic                          move_valid;
    logic                          move_ready;
    logic                          busy;
    logic                          gen_done;
    logic [7:0]                    move_count;

    modport master (
        input  start, unit_done, fifo_empty, fifo_data, move_ready,
        output fifo_rden, move_data, move_valid, busy, gen_done, move_count
    );

    modport slave (
        output start, unit_done, fifo_empty, fifo_data, move_ready,
        input  fifo_rden, move_data, move_valid, busy, gen_done, move_count
    );
endinterface

// File: rtl/move_collector.sv
// move_collector: scans the square units' move FIFOs round-robin, reads one
// word per non-empty FIFO visit, drops invalid slots and streams the valid
// moves one per cycle to the evaluator. Pulses gen_done once every unit is
// done and every FIFO is empty.
// Ports:
//   clk    system clock
//   reset  asynchronous active-high reset
//   bus    move_collector_if.master (FIFO reads, move stream, status)
// Build option: COLLECT_COUNT_EN -- when defined, move_count counts emitted
// moves (saturating at 255); when undefined, move_count is tied to 0.
//
// state  | meaning
// IDLE   | waiting for start
// SCAN   | testing unit ptr; read it, skip it, or finish the pass
// WAIT   | read data arrives; latch word and valid-slot mask
// EMIT   | stream the lowest remaining valid slot
// FINISH | one-cycle gen_done, then back to IDLE
module move_collector #(
    parameter int NUM_UNITS = 64,
    parameter int SLOTS     = 8,
    parameter int MW        = 19
) (
    input  logic             clk,
    input  logic             reset,
    move_collector_if.master bus
);
    localparam int PW = $clog2(NUM_UNITS);
    localparam int SW = $clog2(SLOTS);
    localparam int WW = SLOTS * MW;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SCAN,
        ST_WAIT,
        ST_EMIT,
        ST_FINISH
    } state_t;

    state_t            state, state_n;
    logic [PW-1:0]     ptr, ptr_n, ptr_inc;
    logic [WW-1:0]     word_reg, word_n, in_word;
    logic [SLOTS-1:0]  slot_mask, mask_n, in_mask, mask_after;
    logic [SW-1:0]     sel_idx;
    logic [NUM_UNITS-1:0] rden;
    logic              all_idle;
    logic              count_inc, count_clr;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= ST_IDLE;
            ptr       <= '0;
            word_reg  <= '0;
            slot_mask <= '0;
        end else begin
            state     <= state_n;
            ptr       <= ptr_n;
            word_reg  <= word_n;
            slot_mask <= mask_n;
        end
    end

    always_comb begin
        all_idle   = (&bus.unit_done) & (&bus.fifo_empty);
        ptr_inc    = (ptr == PW'(NUM_UNITS - 1)) ? '0 : ptr + 1'b1;
        in_word    = bus.fifo_data[ptr*WW +: WW];
        in_mask    = '0;
        for (int i = 0; i < SLOTS; i++) begin
            in_mask[i] = ~in_word[i*MW + MW - 1];
        end
        sel_idx = '0;
        for (int i = SLOTS - 1; i >= 0; i--) begin
            if (slot_mask[i]) sel_idx = SW'(i);
        end
        // clears the lowest set bit, i.e. the slot being handed over
        mask_after = slot_mask & (slot_mask - 1'b1);
    end

    always_comb begin
        state_n   = state;
        ptr_n     = ptr;
        word_n    = word_reg;
        mask_n    = slot_mask;
        rden      = '0;
        count_inc = 1'b0;
        count_clr = 1'b0;
        case (state)
            ST_IDLE: ;
            ST_SCAN: begin
                if (all_idle) begin
                    state_n = ST_FINISH;
                end else if (!bus.fifo_empty[ptr]) begin
                    rden[ptr] = 1'b1;
                    state_n   = ST_WAIT;
                end else begin
                    ptr_n = ptr_inc;
                end
            end
            ST_WAIT: begin
                word_n = in_word;
                mask_n = in_mask;
                if (in_mask == '0) begin
                    state_n = ST_SCAN;
                    ptr_n   = ptr_inc;
                end else begin
                    state_n = ST_EMIT;
                end
            end
            ST_EMIT: begin
                if (bus.move_ready) begin
                    mask_n    = mask_after;
                    count_inc = 1'b1;
                    if (mask_after == '0) begin
                        state_n = ST_SCAN;
                        ptr_n   = ptr_inc;
                    end
                end
            end
            ST_FINISH: state_n = ST_IDLE;
            default:   state_n = ST_IDLE;
        endcase
        // start from any state (re)opens a pass; a word read this cycle is lost
        if (bus.start) begin
            state_n   = ST_SCAN;
            ptr_n     = '0;
            mask_n    = '0;
            count_inc = 1'b0;
            count_clr = 1'b1;
        end
    end

    assign bus.fifo_rden  = rden;
    assign bus.move_valid = (state == ST_EMIT);
    assign bus.move_data  = (state == ST_EMIT) ? word_reg[sel_idx*MW +: MW] : '0;
    assign bus.busy       = (state == ST_SCAN) || (state == ST_WAIT) || (state == ST_EMIT);
    assign bus.gen_done   = (state == ST_FINISH);

`ifdef COLLECT_COUNT_EN
    logic [7:0] count_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else if (count_clr) begin
            count_q <= '0;
        end else if (count_inc && (count_q != 8'hFF)) begin
            count_q <= count_q + 1'b1;
        end
    end

    assign bus.move_count = count_q;
`else
    logic count_unused;
    assign count_unused   = count_inc | count_clr;
    assign bus.move_count = '0;
`endif

endmodule

// File: doc/move_collector.md
# move_collector

Downstream stage of the per-square move generators. Once a board is loaded, it scans the 64 square units' move FIFOs round-robin and reads each non-empty FIFO word (eight packed 19-bit move slots). It discards invalid slots and streams the valid moves one per cycle over a valid/ready handshake to the move-evaluation stage. It signals completion when every square unit reports done and every FIFO is empty.

## Interface
Parameters:
- NUM_UNITS, 64, number of square units scanned. Index = {ypos, xpos}.
- SLOTS, 8, moves per FIFO word.
- MW, 19, move width. Format is [invalid][promote][pawn][pawn2][ep][castle][capture][from6][to6].

Ports:
- clk  in  1  system clock; all state on rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle pulse after the board is loaded; begins a collection pass.
- unit_done  in  NUM_UNITS  per-unit done flags.
- fifo_empty  in  NUM_UNITS  per-unit FIFO empty flags.
- fifo_data  in  NUM_UNITS*SLOTS*MW  concatenated FIFO read data; unit u occupies bits [u*152 +: 152].
- fifo_rden  out  NUM_UNITS  one-hot read enable; at most one bit high per cycle.
- move_data  out  MW  current move.
- move_valid  out  1  move_data is valid.
- move_ready  in  1  consumer accepts the move when move_valid && move_ready.
- busy  out  1  high from start until pass completion.
- gen_done  out  1  one-cycle pulse at pass completion.
- move_count  out  8  valid moves emitted this pass; saturates at 255.

## Operation
- FSM states:
  - IDLE: waits for start. start → SCAN, ptr=0, move_count=0.
  - SCAN: tests unit ptr.
    - If fifo_empty[ptr]=0: assert fifo_rden[ptr] for this cycle only → WAIT.
    - Otherwise ptr=ptr+1 mod NUM_UNITS and stay in SCAN.
    - If &unit_done && &fifo_empty in the same cycle → FINISH; this takes priority over the ptr advance.
  - WAIT: FIFO data is valid the cycle after rden. Latch fifo_data for unit ptr into word_reg. Set slot_mask[i] = ~word_reg slot i bit 18 (invalid) → EMIT. If the latched mask is all zero → SCAN with ptr+1.
  - EMIT: move_data = lowest-index slot with slot_mask set (slot 0 = bits 18:0).
    - On handshake: clear that mask bit, increment move_count (saturating).
    - When the last set bit is consumed → SCAN, ptr+1.
    - While move_ready is low, move_data and move_valid hold stable.
  - FINISH: gen_done high for one cycle, busy low → IDLE.
- Round-robin: after servicing unit u, scanning resumes at u+1. Each FIFO gets at most one word per visit, so no unit starves.
- start while busy restarts the pass: → SCAN, ptr=0, count=0, mask cleared, move_valid dropped. A read already issued whose data arrives next cycle is dropped.
- fifo_rden is combinational from state==SCAN, fifo_empty[ptr] and the completion check. It is never asserted in IDLE, WAIT, EMIT or FINISH.

## Timing
- Reset values: state=IDLE, ptr=0, word_reg=0, slot_mask=0, move_data=0, move_valid=0, fifo_rden=0, busy=0, gen_done=0, move_count=0.
- busy rises the cycle after start.
- Latency from rden to first move_valid: 2 cycles (WAIT, then EMIT).
- Throughput: one move per cycle while move_ready=1. Per FIFO word, overhead is one SCAN cycle plus one WAIT cycle.
- Empty-unit skip costs 1 cycle per unit. A full pass with no moves takes 64 cycles.
- Completion is evaluated only in SCAN, so a word in WAIT or EMIT always drains before gen_done.
- A unit that refills after being skipped is picked up on the next lap.
- Saturation: move_count stays at 255. Moves keep streaming.

## Configuration
- COLLECT_COUNT_EN:
  - Defined: move_count is implemented as specified.
  - Undefined: the counter logic is omitted and move_count is tied to 0. All other behaviour is identical.

## Test plan
- Reset mid-EMIT with move_valid=1: all outputs return to their reset values asynchronously. A subsequent start scans from unit 0.
- Unit 5 holds one word with only slots 0 and 3 valid, move_ready=1, all other FIFOs empty, all unit_done=1:
  - fifo_rden[5] one cycle.
  - Two moves emitted in order, slot 0 then slot 3.
  - move_count=2.
  - gen_done pulses once when SCAN next sees every unit done and every FIFO empty.
- Word with all eight invalid bits set: zero moves emitted, scan resumes at unit 6, move_count=0.
- move_ready held low 10 cycles with a move pending: move_data stays stable and move_valid stays high. On release, the move is taken exactly once.
- Units 2 and 60 both non-empty, each refilled after every read for 3 words: reads alternate 2, 60, 2, 60, 2, 60. No double read occurs within a single lap.
- start pulsed while in EMIT: move_valid drops next cycle, move_count=0, ptr=0. Build with COLLECT_COUNT_EN undefined: move_count stays 0 throughout.
